sdram_frame_arbiter: RTL

- Schedules SDRAM burst traffic between the camera write FIFO, the LCD read FIFO and periodic auto-refresh.
- Issues one command at a time to the SDRAM command controller.
- Maintains per-frame linear addresses and double-buffer selection, so the LCD only reads completed camera frames.
- Sits between the FIFO pair and the SDRAM command/timing engine, in the clk_ref (100 MHz) domain.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_frame_addr_gen.sv | 102 ++++++++++
 rtl/sdram_frame_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared encodings and defaults for the SDRAM frame arbiter.
package sdram_arb_pkg;

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_REF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  localparam int DEF_BURST_LEN   = 64;
  localparam int DEF_FRAME_WORDS = 130560;

endpackage

// File: rtl/sdram_frame_addr_gen.sv
// Frame pointers, read wrap, double-buffer selection and pending frame starts.
// Double buffering is enabled by defining ARB_DOUBLE_BUFFER_EN.
module sdram_frame_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int                ADDR_W      = 24,
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(24'h100000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_idle,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  input  logic              wr_adv,
  input  logic              rd_adv,
  input  logic              wr_level_ok,
  output logic              wr_room,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic              wr_overrun
);

  localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL = ADDR_W'(BURST_LEN);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_eff, rd_ptr_eff, rd_ptr_inc;
  logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic              ovr_q, ovr_d;
  logic              wr_apply, rd_apply, wr_buf_eff, rd_buf_eff;

  // Frame starts take effect only in IDLE, so they always land before arbitration.
  assign wr_apply   = in_idle & (wr_frame_start | wr_pend_q);
  assign rd_apply   = in_idle & (rd_frame_start | rd_pend_q);
  assign wr_ptr_eff = wr_apply ? '0 : wr_ptr_q;
  assign rd_ptr_eff = rd_apply ? '0 : rd_ptr_q;
  assign rd_ptr_inc = rd_ptr_eff + BL;

  always_comb begin
    wr_ptr_d  = wr_adv ? (wr_ptr_eff + BL) : wr_ptr_eff;
    rd_ptr_d  = rd_adv ? ((rd_ptr_inc >= FW) ? '0 : rd_ptr_inc) : rd_ptr_eff;
    wr_pend_d = in_idle ? 1'b0 : (wr_pend_q | wr_frame_start);
    rd_pend_d = in_idle ? 1'b0 : (rd_pend_q | rd_frame_start);
    ovr_d     = ovr_q | (wr_level_ok & (wr_ptr_eff >= FW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef ARB_DOUBLE_BUFFER_EN
  logic wr_buf_q, rd_buf_q, last_done_q, last_done_eff, wr_done;

  // A simultaneous read start picks up the frame completed by the write start.
  assign wr_done       = wr_apply & (wr_ptr_q >= FW);
  assign wr_buf_eff    = wr_done ? ~wr_buf_q : wr_buf_q;
  assign last_done_eff = wr_done ? wr_buf_q : last_done_q;
  assign rd_buf_eff    = rd_apply ? last_done_eff : rd_buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      last_done_q <= 1'b0;
    end else begin
      wr_buf_q    <= wr_buf_eff;
      rd_buf_q    <= rd_buf_eff;
      last_done_q <= last_done_eff;
    end
  end

  assign wr_buf = wr_buf_q;
  assign rd_buf = rd_buf_q;
`else
  assign wr_buf_eff = 1'b0;
  assign rd_buf_eff = 1'b0;
  assign wr_buf     = 1'b0;
  assign rd_buf     = 1'b0;
`endif

  assign wr_room    = wr_ptr_eff < FW;
  assign wr_addr    = (wr_buf_eff ? BUF1_BASE : '0) + wr_ptr_eff;
  assign rd_addr    = (rd_buf_eff ? BUF1_BASE : '0) + rd_ptr_eff;
  assign wr_overrun = ovr_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates camera writes, LCD reads and refresh onto one SDRAM command port.
// Define ARB_DOUBLE_BUFFER_EN for double-buffered frames.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                ADDR_W      = 24,
  parameter int                LVL_W       = 10,
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int                RD_LOW_WM   = 256,
  parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(24'h100000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic              ref_req,
  output logic              ref_ack,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic              wr_frame_start,
  input  logic [LVL_W-1:0]  rd_fifo_level,
  input  logic              rd_frame_start,
  output logic              cmd_req,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic              wr_overrun,
  output logic [1:0]        dbg_state
);

  // Command handshake: cmd_req is valid, cmd_ack is ready; a command transfers on
  // the cycle both are high, and cmd_req with every cmd_* field is stable until then.

  localparam logic [LVL_W-1:0] LVL_BL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_WM = LVL_W'(RD_LOW_WM);

  arb_state_e        state_q, state_d;
  logic [1:0]        cmd_op_q, sel_op;
  logic [ADDR_W-1:0] cmd_addr_q, wr_addr, rd_addr;
  logic [8:0]        cmd_len_q;
  logic              last_grant_q;
  logic              sel_valid, load, want_wr, want_rd, wr_room, wr_level_ok;
  logic              acked, wr_adv, rd_adv;

  sdram_frame_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .BUF1_BASE   (BUF1_BASE)
  ) u_addr_gen (
    .clk            (clk),
    .rst            (rst),
    .in_idle        (state_q == ST_IDLE),
    .wr_frame_start (wr_frame_start),
    .rd_frame_start (rd_frame_start),
    .wr_adv         (wr_adv),
    .rd_adv         (rd_adv),
    .wr_level_ok    (wr_level_ok),
    .wr_room        (wr_room),
    .wr_addr        (wr_addr),
    .rd_addr        (rd_addr),
    .wr_buf         (wr_buf),
    .rd_buf         (rd_buf),
    .wr_overrun     (wr_overrun)
  );

  assign wr_level_ok = wr_fifo_level >= LVL_BL;
  assign want_wr     = wr_level_ok & wr_room;
  assign want_rd     = rd_fifo_level <= LVL_WM;

  // last_grant_q = 1 means the previous data grant was a write.
  always_comb begin
    sel_valid = 1'b1;
    sel_op    = OP_REF;
    if (ref_req)                                  sel_op = OP_REF;
    else if (want_wr && (!want_rd || !last_grant_q)) sel_op = OP_WR;
    else if (want_rd)                             sel_op = OP_RD;
    else                                          sel_valid = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sdram_init_done && sel_valid) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
        end
      end
      ST_ISSUE: if (cmd_ack)  state_d = ST_BUSY;
      ST_BUSY:  if (cmd_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_op_q     <= 2'b00;
      cmd_addr_q   <= '0;
      cmd_len_q    <= 9'd0;
      last_grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cmd_op_q   <= sel_op;
        cmd_addr_q <= (sel_op == OP_WR) ? wr_addr : (sel_op == OP_RD) ? rd_addr : '0;
        cmd_len_q  <= (sel_op == OP_REF) ? 9'd0 : 9'(BURST_LEN);
        if (sel_op != OP_REF) last_grant_q <= (sel_op == OP_WR);
      end
    end
  end

  assign acked     = (state_q == ST_ISSUE) & cmd_ack;
  assign wr_adv    = acked & (cmd_op_q == OP_WR);
  assign rd_adv    = acked & (cmd_op_q == OP_RD);
  assign ref_ack   = acked & (cmd_op_q == OP_REF);
  assign cmd_req   = state_q == ST_ISSUE;
  assign cmd_op    = cmd_op_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign dbg_state = state_q;

endmodule
